// File: rtl/instr_pkg.sv
// Shared instruction-format definitions for the encoder/loader and the core's decoder.
package instr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;

  typedef enum logic [3:0] {
    OpNop  = 4'd0,
    OpAdd  = 4'd1,
    OpSub  = 4'd2,
    OpSll  = 4'd3,
    OpSrl  = 4'd4,
    OpAddi = 4'd5,
    OpSubi = 4'd6,
    OpJ    = 4'd7,
    OpBeq  = 4'd8
  } op_sel_e;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StWrite,
    StFull,
    StDone
  } state_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Descriptor handshake plus instruction-memory write port of the program loader.
interface instr_encoder_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic [4:0]        rs_in;
    logic [4:0]        rt_in;
    logic [4:0]        rd_in;
    logic [25:0]       imm_in;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, op_sel, rs_in, rt_in, rd_in, imm_in,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, op_sel, rs_in, rt_in, rd_in, imm_in,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encode.sv
// Combinational map from a symbolic descriptor to the 32-bit instruction word.
module instr_encode
    import instr_pkg::*;
(
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_sel_e'(op_sel))
            OpNop:  word = '0;
            OpAdd:  word = {OP_RTYPE, rs, rt, rd, 5'd0, F_ADD};
            OpSub:  word = {OP_RTYPE, rs, rt, rd, 5'd0, F_SUB};
            OpSll:  word = {OP_RTYPE, rs, rt, rd, imm[4:0], F_SLL};
            OpSrl:  word = {OP_RTYPE, rs, rt, rd, imm[4:0], F_SRL};
            OpAddi: word = {OP_ADDI, rs, rt, imm[15:0]};
            OpSubi: word = {OP_SUBI, rs, rt, imm[15:0]};
            OpJ:    word = {OP_J, imm};
            OpBeq:  word = {OP_BEQ, rs, rt, imm[15:0]};
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts instruction descriptors, encodes them and writes them sequentially into
// instruction memory starting at BASE_ADDR.
module instr_encoder_loader
    import instr_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   finish,
    instr_encoder_loader_if.slave  bus,
    output logic [ADDR_W:0]        count,
    output logic                   full,
    output logic                   done,
    output logic                   err_illegal
);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       word_q;
    logic              we_q, ready_q, full_q, done_q, err_q;

    logic [31:0] enc_word;
    logic        enc_illegal;

    instr_encode u_encode (
        .op_sel  (bus.op_sel),
        .rs      (bus.rs_in),
        .rt      (bus.rt_in),
        .rd      (bus.rd_in),
        .imm     (bus.imm_in),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= BASE;
            count_q <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (start) begin
            // A write being driven this cycle lands on this edge, so restarting here
            // still lets it complete. Start also takes priority over finish.
            state_q <= StAccept;
            addr_q  <= BASE;
            count_q <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StAccept: begin
                    if (finish) begin
                        state_q <= StDone;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (bus.in_valid) begin
                        if (enc_illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= StWrite;
                            word_q  <= enc_word;
                            we_q    <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                StWrite: begin
                    we_q    <= 1'b0;
                    addr_q  <= addr_q + ADDR_W'(1);
                    count_q <= count_q + (ADDR_W + 1)'(1);
                    if (finish) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else if (count_q + (ADDR_W + 1)'(1) == DEPTH_C) begin
                        state_q <= StFull;
                        full_q  <= 1'b1;
                    end else begin
                        state_q <= StAccept;
                        ready_q <= 1'b1;
                    end
                end
                StFull: begin
                    if (finish) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = word_q;
    assign count          = count_q;
    assign full           = full_q;
    assign done           = done_q;
    assign err_illegal    = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding table plus handshake/FSM corner cases.
module tb_instr_encoder_loader;
    import instr_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       finish = 1'b0;
    logic [8:0] count;
    logic       full, done, err_illegal;

    instr_encoder_loader_if #(.ADDR_W(8)) bus ();

    instr_encoder_loader #(
        .ADDR_W    (8),
        .DEPTH     (4),
        .BASE_ADDR (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .finish      (finish),
        .bus         (bus),
        .count       (count),
        .full        (full),
        .done        (done),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [25:0] imm;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[12];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Offers a descriptor until it is accepted; returns inside the WRITE cycle for legal ops.
    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [25:0] imm, output bit ok);
        bus.op_sel   = op;
        bus.rs_in    = rs;
        bus.rt_in    = rt;
        bus.rd_in    = rd;
        bus.imm_in   = imm;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.in_ready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        bus.in_valid = 1'b0;
        bus.op_sel   = '0;
        bus.rs_in    = '0;
        bus.rt_in    = '0;
        bus.rd_in    = '0;
        bus.imm_in   = '0;

        vecs[0]  = '{4'd5, 5'd1,  5'd2,  5'd0, 26'd5,        32'h20220005};
        vecs[1]  = '{4'd1, 5'd1,  5'd2,  5'd3, 26'd0,        32'h00221820};
        vecs[2]  = '{4'd6, 5'd4,  5'd4,  5'd0, 26'h000FFFF,  32'h2484FFFF};
        vecs[3]  = '{4'd7, 5'd0,  5'd0,  5'd0, 26'h10,       32'h08000010};
        vecs[4]  = '{4'd8, 5'd1,  5'd2,  5'd0, 26'd3,        32'h10220003};
        vecs[5]  = '{4'd2, 5'd5,  5'd6,  5'd7, 26'd0,        32'h00A63822};
        vecs[6]  = '{4'd3, 5'd0,  5'd8,  5'd9, 26'h3FFFFE3,  32'h000848C0};
        vecs[7]  = '{4'd4, 5'd1,  5'd2,  5'd3, 26'd31,       32'h00221FC2};
        vecs[8]  = '{4'd0, 5'd31, 5'd7,  5'd3, 26'h1234,     32'h00000000};
        vecs[9]  = '{4'd3, 5'd0,  5'd0,  5'd0, 26'd0,        32'h00000000};
        vecs[10] = '{4'd5, 5'd31, 5'd31, 5'd0, 26'h3FF1234,  32'h23FF1234};
        vecs[11] = '{4'd7, 5'd0,  5'd0,  5'd0, 26'h3FFFFFF,  32'h0BFFFFFF};

        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset imem_we", 32'(bus.imem_we), 32'd0);
        chk("reset imem_addr", 32'(bus.imem_addr), 32'd0);
        chk("reset imem_wdata", bus.imem_wdata, 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset flags", {29'd0, full, done, err_illegal}, 32'd0);
        #11 rst_n = 1'b1;
        step();
        chk("idle in_ready", 32'(bus.in_ready), 32'd0);

        // Encoding table, four words per load so every batch also fills DEPTH.
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0) begin
                pulse_start();
                chk($sformatf("v%0d start count", i), 32'(count), 32'd0);
            end
            send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, ok);
            chk($sformatf("v%0d accepted", i), 32'(ok), 32'd1);
            chk($sformatf("v%0d imem_we", i), 32'(bus.imem_we), 32'd1);
            chk($sformatf("v%0d wdata", i), bus.imem_wdata, vecs[i].exp_word);
            chk($sformatf("v%0d addr", i), 32'(bus.imem_addr), 32'(i % 4));
            chk($sformatf("v%0d ready in write", i), 32'(bus.in_ready), 32'd0);
            step();
            chk($sformatf("v%0d we drop", i), 32'(bus.imem_we), 32'd0);
            chk($sformatf("v%0d count", i), 32'(count), 32'(i % 4 + 1));
            chk($sformatf("v%0d full", i), 32'(full), 32'(i % 4 == 3));
        end

        // Illegal op: flagged, nothing written, following legal op still written.
        pulse_start();
        bus.op_sel = 4'hF;
        bus.in_valid = 1'b1;
        chk("illegal ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("illegal err", 32'(err_illegal), 32'd1);
        chk("illegal no write", 32'(bus.imem_we), 32'd0);
        chk("illegal count", 32'(count), 32'd0);
        chk("illegal still ready", 32'(bus.in_ready), 32'd1);
        send(4'd5, 5'd1, 5'd2, 5'd0, 26'd5, ok);
        chk("post-illegal we", 32'(bus.imem_we), 32'd1);
        chk("post-illegal wdata", bus.imem_wdata, 32'h20220005);
        chk("post-illegal addr", 32'(bus.imem_addr), 32'd0);
        step();
        chk("post-illegal count", 32'(count), 32'd1);
        chk("err sticky", 32'(err_illegal), 32'd1);
        pulse_start();
        chk("start clears err", 32'(err_illegal), 32'd0);

        // Overflow: fifth descriptor never accepted, then finish and restart.
        for (int i = 0; i < 4; i++) begin
            send(4'd1, 5'(i), 5'd2, 5'd3, 26'd0, ok);
            chk($sformatf("fill%0d accepted", i), 32'(ok), 32'd1);
            step();
        end
        bus.op_sel = 4'd1;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("overflow ready c%0d", n), 32'(bus.in_ready), 32'd0);
            step();
            chk($sformatf("overflow we c%0d", n), 32'(bus.imem_we), 32'd0);
        end
        bus.in_valid = 1'b0;
        chk("overflow count", 32'(count), 32'd4);
        chk("overflow full", 32'(full), 32'd1);
        finish = 1'b1;
        step();
        finish = 1'b0;
        chk("finish done", 32'(done), 32'd1);
        chk("done ready", 32'(bus.in_ready), 32'd0);
        pulse_start();
        chk("restart count", 32'(count), 32'd0);
        chk("restart addr", 32'(bus.imem_addr), 32'd0);
        chk("restart full", 32'(full), 32'd0);
        chk("restart done", 32'(done), 32'd0);
        chk("restart ready", 32'(bus.in_ready), 32'd1);

        // Finish during WRITE: the write completes, then DONE.
        send(4'd8, 5'd1, 5'd2, 5'd0, 26'd3, ok);
        finish = 1'b1;
        chk("finish-in-write we", 32'(bus.imem_we), 32'd1);
        step();
        finish = 1'b0;
        chk("finish-in-write done", 32'(done), 32'd1);
        chk("finish-in-write count", 32'(count), 32'd1);

        // Start and finish together: start wins.
        start = 1'b1;
        finish = 1'b1;
        step();
        start = 1'b0;
        finish = 1'b0;
        chk("start+finish done", 32'(done), 32'd0);
        chk("start+finish ready", 32'(bus.in_ready), 32'd1);

        // Reset asserted during the WRITE cycle.
        send(4'd5, 5'd1, 5'd2, 5'd0, 26'd5, ok);
        chk("pre-reset we", 32'(bus.imem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset we", 32'(bus.imem_we), 32'd0);
        chk("async reset wdata", bus.imem_wdata, 32'd0);
        chk("async reset addr", 32'(bus.imem_addr), 32'd0);
        chk("async reset count", 32'(count), 32'd0);
        chk("async reset ready", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b1;
        step();
        step();
        chk("post-reset idle ready", 32'(bus.in_ready), 32'd0);
        chk("post-reset idle we", 32'(bus.imem_we), 32'd0);
        pulse_start();
        chk("post-reset start ready", 32'(bus.in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
